// File: rtl/sll_shift_unit.sv
// ---------------------------------------------------------------------------
// sll_shift_unit
//   Registered logical-left-shift unit for the 16-bit ALU datapath.
//   A is shifted left by shamt and the low bits are filled with zeros. A
//   log2 barrel shifter does the shift: stages of 1, 2, 4 and 8 bits, applied
//   in that order. One output register stage follows the shifter, so results
//   appear one clock after the inputs are sampled.
//
//   Optional feature macro: SLL_CARRY_OUT_EN
//     When it is defined, a carry output is added. It holds the last bit
//     shifted out past the MSB (A[WIDTH-shamt]), or 0 when shamt == 0.
//
//   Parameters
//     WIDTH    operand/result width (default 16)
//     SHAMT_W  shift-amount width, must equal log2(WIDTH) (default 4)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   A/shamt are sampled at this edge
//     A          operand to shift
//     shamt      unsigned shift amount, 0..WIDTH-1
//     SLLResult  registered A << shamt
//     out_valid  SLLResult and flags are valid
//     zero       registered; 1 when SLLResult is all zeros
//     carry      registered last bit shifted out (SLL_CARRY_OUT_EN only)
// ---------------------------------------------------------------------------
module sll_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   SLLResult,
  output logic               out_valid,
`ifdef SLL_CARRY_OUT_EN
  output logic               zero,
  output logic               carry
`else
  output logic               zero
`endif
);

  // One barrel stage: shift left by 2^k when en is set, otherwise pass through.
  function automatic logic [WIDTH-1:0] sll_stage(input logic [WIDTH-1:0] v,
                                                 input int               k,
                                                 input logic             en);
    logic [WIDTH-1:0] r;
    r = en ? (v << (1 << k)) : v;
    return r;
  endfunction

  logic [WIDTH-1:0] stg_p0 [SHAMT_W+1];
  logic [WIDTH-1:0] shifted_p0;
  logic             zero_p0;

  always_comb begin
    stg_p0[0] = A;
    for (int k = 0; k < SHAMT_W; k++) begin
      stg_p0[k+1] = sll_stage(stg_p0[k], k, shamt[k]);
    end
    shifted_p0 = stg_p0[SHAMT_W];
    zero_p0    = (shifted_p0 == '0);
  end

`ifdef SLL_CARRY_OUT_EN
  logic carry_p0;

  // The last bit to leave the MSB is A[WIDTH-shamt]. With no shift, nothing
  // leaves, so carry is 0.
  always_comb begin
    carry_p0 = 1'b0;
    if (shamt != '0) begin
      carry_p0 = A[WIDTH - int'(shamt)];
    end
  end
`endif

  // ---- p0 -> p1: output register stage --------------------------------------
  logic [WIDTH-1:0] res_p1;
  logic             zero_p1;
  logic             vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1  <= shifted_p0;
        zero_p1 <= zero_p0;
      end
    end
  end

`ifdef SLL_CARRY_OUT_EN
  logic carry_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_p1 <= 1'b0;
    end else if (in_valid) begin
      carry_p1 <= carry_p0;
    end
  end

  assign carry = carry_p1;
`endif

  assign SLLResult = res_p1;
  assign zero      = zero_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_sll_shift_unit.sv
module tb_sll_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [3:0]  shamt;
  logic [15:0] SLLResult;
  logic        out_valid;
  logic        zero;
`ifdef SLL_CARRY_OUT_EN
  logic        carry;
`endif

  int checks = 0;
  int errors = 0;

  sll_shift_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .shamt     (shamt),
    .SLLResult (SLLResult),
    .out_valid (out_valid),
`ifdef SLL_CARRY_OUT_EN
    .zero      (zero),
    .carry     (carry)
`else
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation, then return 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic [15:0] a, input logic [3:0] s);
    in_valid = v;
    A        = a;
    shamt    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; A = 16'h0; shamt = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (SLLResult !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp %h", SLLResult, 16'h0000); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero); end
`ifdef SLL_CARRY_OUT_EN
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", carry); end
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [15:0] a_t [4] = '{16'h000F, 16'h008E, 16'h006F, 16'h006F};
    logic [3:0]  s_t [4] = '{4'd1, 4'd1, 4'd1, 4'd2};
    logic [15:0] e_t [4] = '{16'h001E, 16'h011C, 16'h00DE, 16'h01BC};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a_t[i], s_t[i]);
      checks++;
      if (SLLResult !== e_t[i]) begin errors++; $display("FAIL basic_result[%0d] got %h exp %h", i, SLLResult, e_t[i]); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b exp 1", i, out_valid); end
    end
  endtask

  task automatic test_more_shifts;
    logic [15:0] a_t [4] = '{16'h00FE, 16'h008E, 16'h008E, 16'h0002};
    logic [3:0]  s_t [4] = '{4'd1, 4'd2, 4'd3, 4'd2};
    logic [15:0] e_t [4] = '{16'h01FC, 16'h0238, 16'h0470, 16'h0008};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a_t[i], s_t[i]);
      checks++;
      if (SLLResult !== e_t[i]) begin errors++; $display("FAIL more_result[%0d] got %h exp %h", i, SLLResult, e_t[i]); end
      checks++;
      if (zero !== 1'b0) begin errors++; $display("FAIL more_zero[%0d] got %b exp 0", i, zero); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL more_valid[%0d] got %b exp 1", i, out_valid); end
    end
  endtask

  task automatic test_boundary;
    logic [15:0] a_t [3] = '{16'hFFFF, 16'h1234, 16'h8000};
    logic [3:0]  s_t [3] = '{4'd15, 4'd0, 4'd1};
    logic [15:0] e_t [3] = '{16'h8000, 16'h1234, 16'h0000};
    logic        z_t [3] = '{1'b0, 1'b0, 1'b1};
    logic        c_t [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a_t[i], s_t[i]);
      checks++;
      if (SLLResult !== e_t[i]) begin errors++; $display("FAIL bound_result[%0d] got %h exp %h", i, SLLResult, e_t[i]); end
      checks++;
      if (zero !== z_t[i]) begin errors++; $display("FAIL bound_zero[%0d] got %b exp %b", i, zero, z_t[i]); end
`ifdef SLL_CARRY_OUT_EN
      checks++;
      if (carry !== c_t[i]) begin errors++; $display("FAIL bound_carry[%0d] got %b exp %b", i, carry, c_t[i]); end
`else
      if (c_t[i] === 1'bx) $display("unreachable");
`endif
    end
    // Idle after the 0x8000<<1 result: the flags must keep their values.
    drive(1'b0, 16'hFFFF, 4'd3);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bound_idle_valid got %b exp 0", out_valid); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL bound_idle_zero got %b exp 1", zero); end
`ifdef SLL_CARRY_OUT_EN
    checks++;
    if (carry !== 1'b1) begin errors++; $display("FAIL bound_idle_carry got %b exp 1", carry); end
`endif
  endtask

  task automatic test_hold;
    drive(1'b1, 16'h008E, 4'd3);
    checks++;
    if (SLLResult !== 16'h0470) begin errors++; $display("FAIL hold_setup got %h exp %h", SLLResult, 16'h0470); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0000 + 16'(i), 4'd0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 0", i, out_valid); end
      checks++;
      if (SLLResult !== 16'h0470) begin errors++; $display("FAIL hold_result[%0d] got %h exp %h", i, SLLResult, 16'h0470); end
      checks++;
      if (zero !== 1'b0) begin errors++; $display("FAIL hold_zero[%0d] got %b exp 0", i, zero); end
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 16'h00FF, 4'd4);
    checks++;
    if (SLLResult !== 16'h0FF0) begin errors++; $display("FAIL mid_setup got %h exp %h", SLLResult, 16'h0FF0); end
    // Assert reset between edges; keep a valid operation on the inputs.
    A = 16'h8000; shamt = 4'd1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (SLLResult !== 16'h0000) begin errors++; $display("FAIL mid_result got %h exp %h", SLLResult, 16'h0000); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL mid_zero got %b exp 0", zero); end
`ifdef SLL_CARRY_OUT_EN
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL mid_carry got %b exp 0", carry); end
`endif
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b0, 16'h0001, 4'd1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid got %b exp 0", out_valid); end
    drive(1'b1, 16'h0001, 4'd8);
    checks++;
    if (SLLResult !== 16'h0100) begin errors++; $display("FAIL mid_new_result got %h exp %h", SLLResult, 16'h0100); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b exp 1", out_valid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_more_shifts;
    test_boundary;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sll_shift_unit.md
Name: sll_shift_unit

Overview:
- Registered 16-bit logical-left-shift unit for the 16-bit CPU ALU datapath.
- Shifts operand A left by a 4-bit amount, zero-filling from the LSB.
- Result, zero flag and optional carry-out are presented one clock later, with a valid qualifier.
- Combinational core is a log2 barrel shifter (stages of 1/2/4/8), followed by one output register stage.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SHAMT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/shamt are sampled this cycle.
- A  input  WIDTH  operand to shift.
- shamt  input  SHAMT_W  unsigned shift amount, 0..WIDTH-1.
- SLLResult  output  WIDTH  registered result, A << shamt.
- out_valid  output  1  SLLResult and flags are valid.
- zero  output  1  registered; 1 when the SLLResult value is all zeros.
- carry  output  1  last bit shifted out (present only with SLL_CARRY_OUT_EN).

Behaviour:
- Reset (rst_n=0, asynchronous, any time): SLLResult=0, out_valid=0, zero=0, carry=0.
- Reset is released synchronously into the next clk edge.
- Core function: next = A shifted left by shamt.
  - Bits [shamt-1:0] are 0.
  - Bits shifted past MSB are discarded.
  - shamt=0 passes A unchanged.
- Barrel stages:
  - Stage k (k=0..SHAMT_W-1) shifts by 2^k when shamt[k]=1, else passes through.
  - Stages are applied in order 1, 2, 4, 8.
- Latency: exactly 1 cycle.
  - Inputs sampled at edge N with in_valid=1 give SLLResult/zero/carry valid after edge N, with out_valid=1.
- in_valid=0 at an edge:
  - out_valid drops to 0.
  - SLLResult, zero and carry hold their previous values; no register update.
- Throughput: one operation per cycle, no backpressure, no stall input.
- zero is computed from the shifted value and registered in the same edge as SLLResult.
- Back-to-back operations are independent; there is no internal state beyond the output registers.
- Reset asserted mid-stream: outputs clear immediately; the first valid result after release requires a new in_valid.
- All arithmetic is unsigned logical; no sign extension.
- Results from X/undefined inputs are not guaranteed.

Optional Feature:
- Macro: SLL_CARRY_OUT_EN.
- Defined:
  - The carry port exists.
  - On a valid sample, carry = A[WIDTH-shamt] when shamt!=0, else 0; it is registered alongside SLLResult.
  - It holds when in_valid=0 and resets to 0.
- Not defined: carry port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> SLLResult=0x0000, out_valid=0, zero=0 immediately, without a clock edge.
- Basic shifts, one per cycle with in_valid=1:
  - 0x000F<<1 -> 0x001E
  - 0x008E<<1 -> 0x011C
  - 0x006F<<1 -> 0x00DE
  - 0x006F<<2 -> 0x01BC
  - each appears one cycle later with out_valid=1.
- More shifts:
  - 0x00FE<<1 -> 0x01FC
  - 0x008E<<2 -> 0x0238
  - 0x008E<<3 -> 0x0470
  - 0x0002<<2 -> 0x0008
  - zero=0 for each.
- Boundaries:
  - 0xFFFF<<15 -> 0x8000 (carry=1 if enabled).
  - 0x1234<<0 -> 0x1234 (carry=0).
  - 0x8000<<1 -> 0x0000, zero=1, carry=1.
- Hold: in_valid=0 after a result of 0x0470 -> out_valid=0 and SLLResult stays 0x0470 for all idle cycles.
